decoder_receiver: RTL
=====================

// Module: decoder_receiver
// PURPOSE
//  Loading-side counterpart of the results sender in IO_Module. Accepts packets on the
//  32-bit CPU bus while Loading_Enable (INT && Load_Process) is high. Each packet is one
//  header word followed by payload words. Payload word pairs form 64-bit elements that are
//  written through the IO memory write port. Completion of each packet and of the full load
//  is reported to IO_Module.
// PARAMETERS
//  ADDRESS_WIDTH  13  memory word-address width; must be <= 16
//  DATA_WIDTH     64  memory data width; fixed at 64 (two bus words per element)
// PORTS
//  CLK                             in   1              single clock, rising edge
//  RST                             in   1              asynchronous, active-low reset
//  CPU_Bus                         in   32             bus word, sampled when Loading_Enable=1
//  Loading_Enable                  in   1              qualifies CPU_Bus; one word per high cycle
//  Done_Loading                    out  1              sticky: last packet fully written
//  Done_Processing_Current_Packet  out  1              1-cycle pulse at end of each packet
//  Memory_WR_Enable                out  1              write strobe, 1 cycle per element
//  Memory_Address_WR               out  ADDRESS_WIDTH  write address
//  Memory_Data_WR                  out  DATA_WIDTH     write data
// BEHAVIOUR
//  Reset: every output is 0, FSM goes to IDLE, and counters and partial data are cleared.
//   Reset is asynchronous and may assert at any time. A partial element or packet is discarded.
//  Header word: [31] last-packet flag; [28:16] element count N (0..8191);
//   [ADDRESS_WIDTH-1:0] base address. All other bits are ignored.
//  FSM states: IDLE, LOW, HIGH, DONE.
//   IDLE: on Loading_Enable, latch the header and clear Done_Loading.
//     If N=0, go to DONE. Otherwise go to LOW.
//   LOW: on Loading_Enable, latch CPU_Bus as bits [31:0] of the element, then go to HIGH.
//   HIGH: on Loading_Enable, form {CPU_Bus, low}, issue the write, and increment the index.
//     If the index reaches N, go to DONE. Otherwise go to LOW.
//   DONE: pulse Done_Processing_Current_Packet for one cycle. If the header [31] flag was
//     set, set Done_Loading. Return to IDLE. No bus word is consumed in DONE.
//  Write timing:
//   - Memory_WR_Enable is registered and goes high the cycle after the high word is accepted.
//   - Address is (base + index) mod 2^ADDRESS_WIDTH, so it wraps past all-ones to 0.
//   - Address and data hold their value when WR_Enable is low.
//   - The final write and the Done pulse are on consecutive cycles: the write first, then Done.
//  Stalls: when Loading_Enable is low in any state, nothing is consumed and nothing is written.
//   Gaps between any two words are legal and do not change the result.
//  Done_Loading stays high until the next header is accepted or RST is asserted.
//  Throughput: one bus word per cycle; one write per two words. No back-pressure.
// CONFIGURATION
//  DECODER_CHECKSUM_EN
//   Defined:
//   - Each packet carries one extra trailer word after the payload (also after the header
//     when N=0).
//   - The trailer equals the XOR of the header and all payload words.
//   - State CHK is inserted before DONE and consumes the trailer.
//   - Extra output port Checksum_Error (out, 1) goes high together with the Done pulse on a
//     mismatch and holds until the next header or reset.
//   - Done_Loading is still set on a mismatch. Writes are never suppressed.
//   Undefined: no trailer word, no CHK state, and no Checksum_Error port.
// TESTING
//  1 Header 0x0002_0010, then words 11111111, 22222222, 33333333, 44444444:
//    -> write @0x010 = 0x22222222_11111111; write @0x011 = 0x44444444_33333333;
//       Done pulse the cycle after the 2nd write; Done_Loading stays 0.
//  2 Header 0x8002_1FFF, then 4 words:
//    -> writes at 0x1FFF then 0x0000 (wrap); Done_Loading=1 after the pulse;
//       the next header clears it.
//  3 Header 0x8000_0005 (N=0)
//    -> no write; Done pulse 1 cycle after the header cycle; Done_Loading=1.
//  4 Test 1 with Loading_Enable low for 3 cycles between every word
//    -> identical writes and data; no extra strobes; Done comes later by the gap cycles.
//  5 RST low for 1 cycle right after the low word of element 0
//    -> all outputs 0 immediately; a fresh test-1 packet then produces correct writes.
//  6 (DECODER_CHECKSUM_EN) Test 1 with trailer 0x0002_0010^0x11111111^0x22222222^0x33333333^0x44444444
//    -> Checksum_Error=0; with the trailer's bit 0 flipped -> Checksum_Error=1 with the pulse.

Source files
------------

// File: rtl/decoder_receiver.sv
// decoder_receiver: loading-side packet decoder for IO_Module.
// Packets arrive on CPU_Bus as one header word followed by payload word pairs
// (low word first, then high word). Each pair becomes one 64-bit element that is
// written to IO memory at (base + element index), wrapping modulo 2^ADDRESS_WIDTH.
//
// Optional feature macro: DECODER_CHECKSUM_EN
//   When defined, every packet carries a trailer word equal to the XOR of the header
//   and all payload words. A CHK state consumes it, and Checksum_Error reports a
//   mismatch alongside the end-of-packet pulse.
//
// Handshake: Loading_Enable is a valid-only qualifier with no ready. A word presented
// while Loading_Enable is high is consumed in IDLE, LOW, HIGH (and CHK). It is ignored
// in DONE, so the sender leaves at least one idle cycle after the last word of a packet.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 LOW, 2 HIGH, 3 CHK, 4 DONE.
module decoder_receiver #(
  parameter int ADDRESS_WIDTH = 13,  // must be <= 16
  parameter int DATA_WIDTH    = 64   // fixed: two bus words per element
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              CPU_Bus,
  input  logic                     Loading_Enable,
  output logic                     Done_Loading,
  output logic                     Done_Processing_Current_Packet,
  output logic                     Memory_WR_Enable,
  output logic [ADDRESS_WIDTH-1:0] Memory_Address_WR,
  output logic [DATA_WIDTH-1:0]    Memory_Data_WR,
`ifdef DECODER_CHECKSUM_EN
  output logic                     Checksum_Error,
`endif
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4
  } state_t;

  // State entered once the payload is exhausted (or immediately for N = 0).
`ifdef DECODER_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t                   state;
  logic                     last_pkt;   // header bit 31
  logic [12:0]              elem_cnt;   // N from the header
  logic [12:0]              elem_idx;   // elements written so far
  logic [ADDRESS_WIDTH-1:0] base_addr;
  logic [31:0]              low_word;   // low half of the element being assembled
`ifdef DECODER_CHECKSUM_EN
  logic [31:0]              chk_acc;    // running XOR of header and payload
  logic                     chk_bad;    // trailer mismatch, published in DONE
`endif

  assign dbg_state = state;

  // Packet FSM with registered outputs; all state is cleared asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state                          <= IDLE;
      last_pkt                       <= 1'b0;
      elem_cnt                       <= '0;
      elem_idx                       <= '0;
      base_addr                      <= '0;
      low_word                       <= '0;
      Done_Loading                   <= 1'b0;
      Done_Processing_Current_Packet <= 1'b0;
      Memory_WR_Enable               <= 1'b0;
      Memory_Address_WR              <= '0;
      Memory_Data_WR                 <= '0;
`ifdef DECODER_CHECKSUM_EN
      chk_acc                        <= '0;
      chk_bad                        <= 1'b0;
      Checksum_Error                 <= 1'b0;
`endif
    end else begin
      // Strobes default low; address and data hold between writes.
      Memory_WR_Enable               <= 1'b0;
      Done_Processing_Current_Packet <= 1'b0;
      case (state)
        IDLE: begin
          if (Loading_Enable) begin
            last_pkt     <= CPU_Bus[31];
            elem_cnt     <= CPU_Bus[28:16];
            base_addr    <= CPU_Bus[ADDRESS_WIDTH-1:0];
            elem_idx     <= '0;
            Done_Loading <= 1'b0;
`ifdef DECODER_CHECKSUM_EN
            chk_acc        <= CPU_Bus;
            chk_bad        <= 1'b0;
            Checksum_Error <= 1'b0;
`endif
            state <= (CPU_Bus[28:16] == 13'd0) ? TAIL : LOW;
          end
        end
        LOW: begin
          if (Loading_Enable) begin
            low_word <= CPU_Bus;
`ifdef DECODER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ CPU_Bus;
`endif
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (Loading_Enable) begin
            Memory_Data_WR    <= {CPU_Bus, low_word};
            Memory_Address_WR <= base_addr + ADDRESS_WIDTH'(elem_idx);
            Memory_WR_Enable  <= 1'b1;
            elem_idx          <= elem_idx + 13'd1;
`ifdef DECODER_CHECKSUM_EN
            chk_acc           <= chk_acc ^ CPU_Bus;
`endif
            state <= (elem_idx + 13'd1 == elem_cnt) ? TAIL : LOW;
          end
        end
`ifdef DECODER_CHECKSUM_EN
        CHK: begin
          if (Loading_Enable) begin
            chk_bad <= (chk_acc != CPU_Bus);
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          Done_Processing_Current_Packet <= 1'b1;
          if (last_pkt) Done_Loading <= 1'b1;
`ifdef DECODER_CHECKSUM_EN
          Checksum_Error <= chk_bad;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
